// File: rtl/pipe_control.sv
// pipe_control: camera->filter->framebuffer pipeline controller.
// Debounced switches, camera start-up retry, frame-aligned apply/flush, threshold.
module pipe_control #(
    parameter int unsigned          N_STAGES     = 2,
    parameter int unsigned          THR_WIDTH    = 26,
    parameter logic [THR_WIDTH-1:0] THR_DEFAULT  = 26'd2000,
    parameter logic [THR_WIDTH-1:0] THR_STEP     = 26'd250,
    parameter logic [THR_WIDTH-1:0] THR_MIN      = 26'd0,
    parameter logic [THR_WIDTH-1:0] THR_MAX      = 26'd60000,
    parameter int unsigned          DB_CYCLES    = 2500000,
    parameter int unsigned          FLUSH_CYCLES = 16,
    parameter int unsigned          CFG_TIMEOUT  = 12500000
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [N_STAGES-1:0]  i_stage_sw,
    input  logic                 i_mode,
    input  logic                 i_inc,
    input  logic                 i_dec,
    input  logic                 i_freeze,
    input  logic                 i_sof,
    input  logic                 i_cfg_done,
    output logic                 o_cam_start,
    output logic [N_STAGES-1:0]  o_stage_en,
    output logic                 o_mode,
    output logic                 o_pipe_flush,
    output logic [THR_WIDTH-1:0] o_threshold,
    output logic                 o_thr_limit,
    output logic                 o_running
);
    localparam int NIN     = N_STAGES + 4;
    localparam int CFGW    = N_STAGES + 2;
    localparam int I_MODE  = N_STAGES;
    localparam int I_INC   = N_STAGES + 1;
    localparam int I_DEC   = N_STAGES + 2;
    localparam int I_FRZ   = N_STAGES + 3;
    localparam int DBW     = $clog2(DB_CYCLES + 1);
    localparam int CTW     = $clog2(CFG_TIMEOUT + 1);
    localparam int FLW     = $clog2(FLUSH_CYCLES + 1);
    localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_CYCLES - 1);
    localparam logic [CTW-1:0] TMO_LAST = CTW'(CFG_TIMEOUT - 1);
    localparam logic [FLW-1:0] FL_LAST  = FLW'(FLUSH_CYCLES - 1);

    localparam logic [2:0] S_BOOT  = 3'd0;
    localparam logic [2:0] S_CFG   = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_PEND  = 3'd3;
    localparam logic [2:0] S_FLUSH = 3'd4;

    logic [NIN-1:0]       w_raw;
    logic [NIN-1:0]       r_s1;
    logic [NIN-1:0]       r_s2;
    logic [NIN-1:0]       r_db;
    logic [DBW-1:0]       r_cnt [NIN];
    logic [1:0]           r_edge_d;
    logic [CFGW-1:0]      w_cfg;
    logic [2:0]           r_state;
    logic [2:0]           w_state_nx;
    logic [CFGW-1:0]      r_app;
    logic [CFGW-1:0]      w_app_nx;
    logic [CFGW-1:0]      r_pend;
    logic [CFGW-1:0]      w_pend_nx;
    logic [CTW-1:0]       r_tmo;
    logic [CTW-1:0]       w_tmo_nx;
    logic [FLW-1:0]       r_fcnt;
    logic [FLW-1:0]       w_fcnt_nx;
    logic                 w_cam_nx;
    logic                 r_cam;
    logic                 r_flush;
    logic                 r_run;
    logic                 w_inc_e;
    logic                 w_dec_e;
    logic [THR_WIDTH:0]   w_up;
    logic [THR_WIDTH:0]   w_dn;
    logic [THR_WIDTH-1:0] w_thr_nx;
    logic [THR_WIDTH-1:0] r_thr;
    logic                 r_lim;

    // freeze is kept as the top bit of the applied configuration
    assign w_raw = {i_freeze, i_dec, i_inc, i_mode, i_stage_sw};
    assign w_cfg = {r_db[I_FRZ], r_db[I_MODE:0]};

    // two-flop synchroniser for every raw board input
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= w_raw;
            r_s2 <= r_s1;
        end
    end

    // per-bit debounce: accept a new level after DB_CYCLES differing samples
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_db <= '0;
            for (int i = 0; i < NIN; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NIN; i++) begin
                if (r_s2[i] == r_db[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == DB_LAST) begin
                    r_db[i]  <= r_s2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + DBW'(1);
                end
            end
        end
    end

    // next-state logic for start-up, change tracking and flush timing
    always_comb begin
        w_state_nx = r_state;
        w_app_nx   = r_app;
        w_pend_nx  = r_pend;
        w_tmo_nx   = r_tmo;
        w_fcnt_nx  = r_fcnt;
        w_cam_nx   = 1'b0;
        case (r_state)
            S_BOOT: begin
                w_state_nx = S_CFG;
                w_cam_nx   = 1'b1;
                w_tmo_nx   = '0;
            end
            S_CFG: begin
                if (i_cfg_done) begin
                    w_pend_nx  = w_cfg;
                    w_state_nx = S_PEND;
                end else if (r_tmo == TMO_LAST) begin
                    w_cam_nx = 1'b1;
                    w_tmo_nx = '0;
                end else begin
                    w_tmo_nx = r_tmo + CTW'(1);
                end
            end
            S_RUN: begin
                if (w_cfg != r_app) begin
                    w_pend_nx  = w_cfg;
                    w_state_nx = S_PEND;
                end
            end
            S_PEND: begin
                w_pend_nx = w_cfg;
                if (i_sof) begin
                    w_app_nx   = w_cfg;
                    w_fcnt_nx  = '0;
                    w_state_nx = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (r_fcnt == FL_LAST) w_state_nx = S_RUN;
                else w_fcnt_nx = r_fcnt + FLW'(1);
            end
            default: w_state_nx = S_BOOT;
        endcase
    end

    // control state and registered control outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_BOOT;
            r_app   <= '0;
            r_pend  <= '0;
            r_tmo   <= '0;
            r_fcnt  <= '0;
            r_cam   <= 1'b0;
            r_flush <= 1'b1;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_app   <= w_app_nx;
            r_pend  <= w_pend_nx;
            r_tmo   <= w_tmo_nx;
            r_fcnt  <= w_fcnt_nx;
            r_cam   <= w_cam_nx;
            r_flush <= (w_state_nx == S_BOOT) || (w_state_nx == S_CFG) ||
                       (w_state_nx == S_FLUSH) || w_app_nx[CFGW-1];
            r_run   <= (w_state_nx == S_RUN) || (w_state_nx == S_PEND) ||
                       (w_state_nx == S_FLUSH);
        end
    end

    // threshold arithmetic one bit wider so overflow/underflow is visible
    assign w_inc_e = r_db[I_INC] & ~r_edge_d[0];
    assign w_dec_e = r_db[I_DEC] & ~r_edge_d[1];
    assign w_up    = {1'b0, r_thr} + {1'b0, THR_STEP};
    assign w_dn    = {1'b0, r_thr} - {1'b0, THR_STEP};

    // clamp the stepped value; simultaneous edges cancel
    always_comb begin
        w_thr_nx = r_thr;
        if (w_inc_e && !w_dec_e) begin
            if (w_up > {1'b0, THR_MAX}) w_thr_nx = THR_MAX;
            else w_thr_nx = w_up[THR_WIDTH-1:0];
        end else if (w_dec_e && !w_inc_e) begin
            if (w_dn[THR_WIDTH] || (w_dn < {1'b0, THR_MIN})) w_thr_nx = THR_MIN;
            else w_thr_nx = w_dn[THR_WIDTH-1:0];
        end
    end

    // threshold register, limit flag and button edge history
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_thr    <= THR_DEFAULT;
            r_lim    <= (THR_DEFAULT == THR_MIN) || (THR_DEFAULT == THR_MAX);
            r_edge_d <= '0;
        end else begin
            r_thr    <= w_thr_nx;
            r_lim    <= (w_thr_nx == THR_MIN) || (w_thr_nx == THR_MAX);
            r_edge_d <= {r_db[I_DEC], r_db[I_INC]};
        end
    end

    assign o_cam_start  = r_cam;
    assign o_stage_en   = r_app[N_STAGES-1:0];
    assign o_mode       = r_app[I_MODE];
    assign o_pipe_flush = r_flush;
    assign o_threshold  = r_thr;
    assign o_thr_limit  = r_lim;
    assign o_running    = r_run;
endmodule

// File: tb/tb_pipe_control.sv
// tb_pipe_control: directed and randomised checks of pipe_control
// against a transaction-level model of the controller.
module tb_pipe_control;
    logic        CLK = 1'b0;
    logic        RST;
    logic [1:0]  i_stage_sw;
    logic        i_mode;
    logic        i_inc;
    logic        i_dec;
    logic        i_freeze;
    logic        i_sof;
    logic        i_cfg_done;
    logic        o_cam_start;
    logic [1:0]  o_stage_en;
    logic        o_mode;
    logic        o_pipe_flush;
    logic [25:0] o_threshold;
    logic        o_thr_limit;
    logic        o_running;

    pipe_control #(
        .DB_CYCLES(4),
        .FLUSH_CYCLES(3),
        .CFG_TIMEOUT(20)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .i_stage_sw(i_stage_sw),
        .i_mode(i_mode),
        .i_inc(i_inc),
        .i_dec(i_dec),
        .i_freeze(i_freeze),
        .i_sof(i_sof),
        .i_cfg_done(i_cfg_done),
        .o_cam_start(o_cam_start),
        .o_stage_en(o_stage_en),
        .o_mode(o_mode),
        .o_pipe_flush(o_pipe_flush),
        .o_threshold(o_threshold),
        .o_thr_limit(o_thr_limit),
        .o_running(o_running)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    // model state: settled switches, applied config, pending flag, threshold
    logic [1:0] m_sw;
    logic       m_mode;
    logic       m_frz;
    logic [1:0] a_sw;
    logic       a_mode;
    logic       a_frz;
    bit         m_pend;
    int         m_thr;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic set_sw(input logic [1:0] s, input logic m, input logic f);
        i_stage_sw = s;
        i_mode = m;
        i_freeze = f;
        tick(8);
        m_sw = s;
        m_mode = m;
        m_frz = f;
        if ({m_sw, m_mode, m_frz} != {a_sw, a_mode, a_frz}) m_pend = 1'b1;
    endtask

    task automatic pulse_sof();
        i_sof = 1'b1;
        tick(1);
        i_sof = 1'b0;
    endtask

    task automatic press(input bit inc, input bit dec);
        i_inc = inc;
        i_dec = dec;
        tick(8);
        i_inc = 1'b0;
        i_dec = 1'b0;
        tick(8);
        if (inc && !dec) m_thr = (m_thr + 250 > 60000) ? 60000 : m_thr + 250;
        if (dec && !inc) m_thr = (m_thr - 250 < 0) ? 0 : m_thr - 250;
    endtask

    // frame start against the model: apply if pending, flush exactly 3 cycles
    task automatic sof_model(input string tag);
        bit fl;
        fl = m_pend;
        pulse_sof();
        if (m_pend) begin
            a_sw = m_sw;
            a_mode = m_mode;
            a_frz = m_frz;
            m_pend = 1'b0;
        end
        check({tag, "_stage"}, 32'(o_stage_en), 32'(a_sw));
        check({tag, "_mode"}, 32'(o_mode), 32'(a_mode));
        check({tag, "_flush0"}, 32'(o_pipe_flush), 32'(fl | a_frz));
        tick(2);
        check({tag, "_flush2"}, 32'(o_pipe_flush), 32'(fl | a_frz));
        tick(1);
        check({tag, "_flush3"}, 32'(o_pipe_flush), 32'(a_frz));
    endtask

    task automatic check_thr(input string tag);
        check({tag, "_thr"}, 32'(o_threshold), 32'(m_thr));
        check({tag, "_lim"}, 32'(o_thr_limit), 32'(m_thr == 0 || m_thr == 60000));
    endtask

    initial begin
        int k;
        int op;
        RST = 1'b1;
        i_stage_sw = '0;
        i_mode = 1'b0;
        i_inc = 1'b0;
        i_dec = 1'b0;
        i_freeze = 1'b0;
        i_sof = 1'b0;
        i_cfg_done = 1'b0;
        m_sw = '0;
        m_mode = 1'b0;
        m_frz = 1'b0;
        a_sw = '0;
        a_mode = 1'b0;
        a_frz = 1'b0;
        m_pend = 1'b0;
        m_thr = 2000;
        tick(3);
        check("rst_cam", 32'(o_cam_start), 32'd0);
        check("rst_stage", 32'(o_stage_en), 32'd0);
        check("rst_mode", 32'(o_mode), 32'd0);
        check("rst_flush", 32'(o_pipe_flush), 32'd1);
        check("rst_run", 32'(o_running), 32'd0);
        check_thr("rst");

        RST = 1'b0;
        tick(1);
        check("boot_cam", 32'(o_cam_start), 32'd1);
        check("cfg_flush", 32'(o_pipe_flush), 32'd1);
        k = 0;
        do begin
            tick(1);
            k++;
        end while (o_cam_start !== 1'b1 && k < 40);
        check("cam_retry_gap", 32'(k), 32'd20);
        check("cfg_run", 32'(o_running), 32'd0);

        i_cfg_done = 1'b1;
        tick(1);
        check("pend_run", 32'(o_running), 32'd1);
        check("pend_flush", 32'(o_pipe_flush), 32'd0);
        m_pend = 1'b1;
        sof_model("first_sof");
        check("first_run", 32'(o_running), 32'd1);

        set_sw(2'b11, 1'b0, 1'b0);
        check("pre_sof_stage", 32'(o_stage_en), 32'd0);
        check("pre_sof_flush", 32'(o_pipe_flush), 32'd0);
        sof_model("stage11");

        i_stage_sw = 2'b00;
        tick(3);
        i_stage_sw = 2'b11;
        i_mode = 1'b1;
        tick(2);
        i_mode = 1'b0;
        tick(10);
        sof_model("glitch");

        for (int i = 0; i < 300; i++) press(1'b1, 1'b0);
        check_thr("sat_max");
        press(1'b0, 1'b1);
        check_thr("one_dec");
        press(1'b1, 1'b1);
        check_thr("inc_dec");

        set_sw(2'b11, 1'b0, 1'b1);
        check("frz_pend_flush", 32'(o_pipe_flush), 32'd0);
        sof_model("frz_on");
        tick(10);
        check("frz_hold", 32'(o_pipe_flush), 32'd1);
        set_sw(2'b11, 1'b0, 1'b0);
        check("frz_off_pend", 32'(o_pipe_flush), 32'd1);
        sof_model("frz_off");

        for (int n = 0; n < 60; n++) begin
            op = int'($urandom_range(0, 5));
            case (op)
                0: begin
                    set_sw(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 3) == 0));
                    check("rnd_sw_stage", 32'(o_stage_en), 32'(a_sw));
                    check("rnd_sw_flush", 32'(o_pipe_flush), 32'(a_frz));
                end
                1: begin
                    i_stage_sw = 2'($urandom_range(0, 3));
                    i_mode = 1'($urandom_range(0, 1));
                    tick(int'($urandom_range(1, 3)));
                    i_stage_sw = m_sw;
                    i_mode = m_mode;
                    tick(8);
                    check("rnd_gl_stage", 32'(o_stage_en), 32'(a_sw));
                    check("rnd_gl_mode", 32'(o_mode), 32'(a_mode));
                end
                2: sof_model("rnd_sof");
                3: begin press(1'b1, 1'b0); check_thr("rnd_inc"); end
                4: begin press(1'b0, 1'b1); check_thr("rnd_dec"); end
                default: begin press(1'b1, 1'b1); check_thr("rnd_both"); end
            endcase
        end

        set_sw(~a_sw, a_mode, a_frz);
        pulse_sof();
        check("pre_rst_flush", 32'(o_pipe_flush), 32'd1);
        RST = 1'b1;
        tick(1);
        check("mid_rst_stage", 32'(o_stage_en), 32'd0);
        check("mid_rst_flush", 32'(o_pipe_flush), 32'd1);
        check("mid_rst_run", 32'(o_running), 32'd0);
        check("mid_rst_cam", 32'(o_cam_start), 32'd0);
        m_thr = 2000;
        check_thr("mid_rst");
        RST = 1'b0;
        tick(1);
        check("rst_cam_again", 32'(o_cam_start), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
